univ_reg: RTL and testbench

- Parametrised successor to the single-bit D latch (EN, D, Q): a WIDTH-bit edge-triggered universal register.
- EN-gated, mode-selected update: hold, parallel load, shift, rotate, up/down count.
- Registered carry/borrow flag and serial output.
- Used as the shared storage/counter/shift primitive in the lab designs that follow.

---
 rtl/univ_reg_pkg.sv | 15 +
 rtl/univ_reg_if.sv | 17 +
 rtl/univ_reg_next.sv | 70 +++++++
 rtl/univ_reg.sv | 58 +++++
 tb/tb_univ_reg.sv | 137 +++++++++++++
 5 files changed

// File: rtl/univ_reg_pkg.sv
// Shared constants for the universal register: mode width and mode encodings.
package univ_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_if.sv
// Control/data bundle of the universal register; master drives controls, slave returns state.
interface univ_reg_if
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              EN;
    logic [MODE_W-1:0] MODE;
    logic [WIDTH-1:0]  D;
    logic              SI;
    logic [WIDTH-1:0]  Q;
    logic              SO;
    logic              CO;

    modport master (output EN, MODE, D, SI, input Q, SO, CO);
    modport slave  (input EN, MODE, D, SI, output Q, SO, CO);
endinterface

// File: rtl/univ_reg_next.sv
// Combinational next-state function: given current Q and inputs, produce the candidate
// Q plus SO/CO values and which flags the selected mode is allowed to write.
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              si_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [WIDTH-1:0]  q_nxt_o,
    output logic              so_nxt_o,
    output logic              co_nxt_o,
    output logic              so_we_o,
    output logic              co_we_o
);
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_sum;

    // One extra bit so the MSB carries out of INC or borrows out of DEC.
    assign inc_sum = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_sum = {1'b0, q_i} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_nxt_o  = q_i;
        so_nxt_o = 1'b0;
        co_nxt_o = 1'b0;
        so_we_o  = 1'b0;
        co_we_o  = 1'b0;
        case (mode_i)
            MODE_HOLD: ;
            MODE_LOAD: begin
                q_nxt_o = d_i;
                co_we_o = 1'b1;
            end
            MODE_SHL: begin
                q_nxt_o  = {q_i[WIDTH-2:0], si_i};
                so_nxt_o = q_i[WIDTH-1];
                so_we_o  = 1'b1;
            end
            MODE_SHR: begin
                q_nxt_o  = {si_i, q_i[WIDTH-1:1]};
                so_nxt_o = q_i[0];
                so_we_o  = 1'b1;
            end
            MODE_ROL: begin
                q_nxt_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                so_nxt_o = q_i[WIDTH-1];
                so_we_o  = 1'b1;
            end
            MODE_ROR: begin
                q_nxt_o  = {q_i[0], q_i[WIDTH-1:1]};
                so_nxt_o = q_i[0];
                so_we_o  = 1'b1;
            end
            MODE_INC: begin
                q_nxt_o  = inc_sum[WIDTH-1:0];
                co_nxt_o = inc_sum[WIDTH];
                co_we_o  = 1'b1;
            end
            MODE_DEC: begin
                q_nxt_o  = dec_sum[WIDTH-1:0];
                co_nxt_o = dec_sum[WIDTH];
                co_we_o  = 1'b1;
            end
            default: q_nxt_o = q_i;
        endcase
    end
endmodule

// File: rtl/univ_reg.sv
// WIDTH-bit universal register: reset/enable-gated flop stage around univ_reg_next.
// All outputs are registered; nothing from the inputs reaches Q/SO/CO combinationally.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    univ_reg_if.slave  bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             co_q, co_d;

    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt, co_nxt, so_we, co_we;

    univ_reg_next #(.WIDTH(WIDTH)) u_next (
        .q_i      (q_q),
        .d_i      (bus.D),
        .si_i     (bus.SI),
        .mode_i   (bus.MODE),
        .q_nxt_o  (q_nxt),
        .so_nxt_o (so_nxt),
        .co_nxt_o (co_nxt),
        .so_we_o  (so_we),
        .co_we_o  (co_we)
    );

    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        co_d = co_q;
        if (bus.EN) begin
            q_d = q_nxt;
            if (so_we) so_d = so_nxt;
            if (co_we) co_d = co_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= RST_VAL;
            so_q <= 1'b0;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
            co_q <= co_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.SO = so_q;
    assign bus.CO = co_q;
endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an integer-arithmetic model.
module tb_univ_reg;
    import univ_reg_pkg::*;

    localparam int          W    = 8;
    localparam int          MODN = 1 << W;
    localparam logic [W-1:0] RV  = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    univ_reg_if #(.WIDTH(W)) bus ();

    univ_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents as a plain integer modulo 2^W.
    int m_q, m_so, m_co;
    bit m_valid = 1'b0;

    initial begin
        int s_en, s_mode, s_d, s_si, msb;
        forever begin
            @(posedge clk);
            s_en = int'(bus.EN); s_mode = int'(bus.MODE); s_d = int'(bus.D); s_si = int'(bus.SI);
            if (rst) begin
                m_q = int'(RV); m_so = 0; m_co = 0; m_valid = 1'b1;
            end else if (m_valid && s_en == 1) begin
                msb = m_q / (MODN / 2);
                case (s_mode)
                    0: ;
                    1: begin m_q = s_d; m_co = 0; end
                    2: begin m_so = msb;      m_q = (m_q * 2 + s_si) % MODN; end
                    3: begin m_so = m_q % 2;  m_q = m_q / 2 + s_si * (MODN / 2); end
                    4: begin m_so = msb;      m_q = (m_q * 2 + msb) % MODN; end
                    5: begin m_so = m_q % 2;  m_q = m_q / 2 + (m_q % 2) * (MODN / 2); end
                    6: begin m_co = (m_q == MODN - 1) ? 1 : 0; m_q = (m_q + 1) % MODN; end
                    default: begin m_co = (m_q == 0) ? 1 : 0; m_q = (m_q + MODN - 1) % MODN; end
                endcase
            end
            #1;
            if (m_valid) begin
                check("model_Q",  32'(bus.Q),  32'(m_q));
                check("model_SO", 32'(bus.SO), 32'(m_so));
                check("model_CO", 32'(bus.CO), 32'(m_co));
            end
        end
    end

    // Drive at the falling edge, return shortly after the following rising edge.
    task automatic step(input logic r, input logic en, input logic [MODE_W-1:0] mode,
                        input logic [W-1:0] d, input logic si);
        @(negedge clk);
        rst = r; bus.EN = en; bus.MODE = mode; bus.D = d; bus.SI = si;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string name, input logic [W-1:0] q,
                                input logic so, input logic co);
        check({name, "_Q"},  32'(bus.Q),  32'(q));
        check({name, "_SO"}, 32'(bus.SO), 32'(so));
        check({name, "_CO"}, 32'(bus.CO), 32'(co));
    endtask

    initial begin
        rst = 1'b1; bus.EN = 1'b0; bus.MODE = MODE_HOLD; bus.D = '0; bus.SI = 1'b0;

        step(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);
        step(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);
        expect_state("reset", 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0);
        expect_state("load", 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, MODE_W'(i), ((i / 5) % 2 == 1) ? 8'hFF : 8'h00, i[0]);
            expect_state("en_gate", 8'h3C, 1'b0, 1'b0);
        end

        step(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0);
        expect_state("shl", 8'h02, 1'b1, 1'b0);
        step(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b1);
        expect_state("shr", 8'h81, 1'b0, 1'b0);

        step(1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0);
        step(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0);
        expect_state("ror", 8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b1);
        check("rol8_Q", 32'(bus.Q), 32'h80);

        step(1'b0, 1'b1, MODE_LOAD, 8'hFE, 1'b0);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        check("inc1_Q", 32'(bus.Q), 32'hFF); check("inc1_CO", 32'(bus.CO), 32'd0);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        check("inc2_Q", 32'(bus.Q), 32'h00); check("inc2_CO", 32'(bus.CO), 32'd1);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        check("inc3_Q", 32'(bus.Q), 32'h01); check("inc3_CO", 32'(bus.CO), 32'd0);
        step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
        check("dec1_Q", 32'(bus.Q), 32'h00); check("dec1_CO", 32'(bus.CO), 32'd0);
        step(1'b0, 1'b1, MODE_DEC, 8'h00, 1'b0);
        check("dec2_Q", 32'(bus.Q), 32'hFF); check("dec2_CO", 32'(bus.CO), 32'd1);

        step(1'b0, 1'b1, MODE_LOAD, 8'h10, 1'b0);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        check("midop_pre_Q", 32'(bus.Q), 32'h12);
        step(1'b1, 1'b1, MODE_INC, 8'h00, 1'b0);
        expect_state("midop_rst", 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
        check("midop_resume_Q", 32'(bus.Q), 32'hA6);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 MODE_W'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
